count_capture_fifo: RTL and testbench
=====================================

Name: count_capture_fifo

Overview:
Downstream consumer of the 4-bit free-running counter. Snapshots the counter value on a capture strobe and buffers the snapshots in a small first-word-fall-through FIFO, which a valid/ready read port drains. Also flags each counter wrap (all-ones to zero) with a one-cycle pulse, and holds a sticky overflow flag for captures lost to a full buffer.

Parameters:
WIDTH, 4, width of count_in and out_data
DEPTH, 8, FIFO entries; must be a power of two, >= 2
ADDR_W, 3, log2(DEPTH); pointer width

Ports:
clock  input  1  rising-edge clock for all state
clear  input  1  asynchronous active-low reset; 0 resets all state immediately
count_in  input  WIDTH  counter value being monitored
capture  input  1  1 = snapshot count_in this cycle
flush  input  1  synchronous: empty FIFO, clear overflow
out_data  output  WIDTH  head-of-FIFO snapshot, meaningful only while out_valid=1
out_valid  output  1  FIFO non-empty
out_ready  input  1  consumer accepts out_data this cycle
full  output  1  level == DEPTH
empty  output  1  level == 0
level  output  ADDR_W+1  current number of stored entries
overflow  output  1  sticky, a capture was dropped
wrap_pulse  output  1  one-cycle pulse, counter wrapped

Behaviour:
- Reset (clear=0, asynchronous):
  - Pointers and level go to 0; empty=1; full=0; out_valid=0.
  - overflow=0; wrap_pulse=0; out_data=0; previous-count register=0.
- Storage: register array; rd_ptr/wr_ptr are ADDR_W bits and wrap modulo DEPTH. level is tracked separately.
- pop = out_valid & out_ready.
- push = capture & (!full | pop). Push is accepted when full only if a pop occurs in the same cycle.
- Write path: on push, mem[wr_ptr] <= count_in as sampled at that edge; wr_ptr increments.
- Read path: on pop, rd_ptr increments.
- level updates by +1 on push only, -1 on pop only, and is unchanged on both or neither.
- Latency: a push into an empty FIFO gives out_valid=1 and out_data=the captured value on the next cycle (1-cycle latency).
- out_data always equals mem[rd_ptr]. It is held stable while out_valid=1 and out_ready=0.
- Empty: out_valid=0; out_ready is ignored and level stays 0.
- Full with capture=1 and no pop: no write, no pointer or level change, overflow <= 1.
- overflow stays set until reset or flush.
- flush=1 has priority over push and pop in the same cycle:
  - Pointers and level go to 0; overflow goes to 0.
  - Any simultaneous capture is discarded and does not set overflow.
- Wrap detect:
  - prev_count <= count_in every cycle.
  - wrap_pulse <= (prev_count == all-ones) & (count_in == 0). This is registered, so the pulse appears one cycle after count_in reads 0.
  - A jump to 0 from any other value (e.g. the counter's own clear) does not pulse.
  - Because prev_count resets to 0, no false pulse occurs on the first cycle after reset.
  - flush does not affect wrap detection.
- Reset mid-operation: all buffered entries are lost; no output glitches after clear deasserts.
- Flags: full, empty and level are registered-state derived and consistent in every cycle.

Test Plan:
- Reset, then capture at count_in=3, 4, 5 on consecutive cycles with out_ready=0:
  - out_valid rises one cycle after the first capture; level=3.
  - Raise out_ready: out_data reads 3, 4, 5 on consecutive cycles, then out_valid=0 and empty=1.
- Capture 9 times with out_ready=0, DEPTH=8: full=1 after the 8th; the 9th sets overflow=1; level stays 8; the drained data is the first 8 values in order.
- When full, assert capture (count_in=0xA) and out_ready together: push accepted, level stays 8, overflow stays 0, and 0xA appears as the last entry on drain.
- Run count_in 0xE, 0xF, 0x0, 0x1: wrap_pulse=1 for exactly the one cycle after 0x0 is presented. Then drive 0x7 to 0x0: no pulse.
- With level=5 and overflow=1, assert flush and capture in the same cycle: next cycle level=0, empty=1, overflow=0, out_valid=0.
- With level=4, pull clear low mid-cycle: outputs go to reset values immediately, before the next clock edge. After release, the first capture of 0x2 reads back as 0x2.

Source files
------------

// File: rtl/count_capture_fifo.sv
// ---------------------------------------------------------------------------
// count_capture_fifo
//
// Sits downstream of a free-running counter. On each capture strobe the
// current count is snapshotted into a small first-word-fall-through FIFO.
// A valid/ready port drains the FIFO. The block also raises a one-cycle
// pulse whenever the counter wraps from all-ones to zero. A sticky overflow
// flag records any capture that was dropped because the buffer was full.
//
// Ports:
//   clock      - rising-edge clock for all state
//   clear      - asynchronous active-low reset
//   count_in   - counter value being monitored (WIDTH bits)
//   capture    - snapshot count_in this cycle
//   flush      - synchronous: empty the FIFO and clear overflow
//   out_data   - head-of-FIFO snapshot, meaningful while out_valid=1
//   out_valid  - FIFO is non-empty
//   out_ready  - consumer accepts out_data this cycle
//   full       - level == DEPTH
//   empty      - level == 0
//   level      - number of stored entries (ADDR_W+1 bits)
//   overflow   - sticky: a capture was dropped
//   wrap_pulse - one-cycle pulse after the counter wrapped to zero
// ---------------------------------------------------------------------------
module count_capture_fifo #(
    parameter int WIDTH  = 4,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clock,
    input  logic              clear,
    input  logic [WIDTH-1:0]  count_in,
    input  logic              capture,
    input  logic              flush,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic              wrap_pulse
);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W:0]   level_q;
    logic [WIDTH-1:0]  prev_count;
    logic              overflow_q;
    logic              wrap_q;
    logic              pop;
    logic              push;

    // Flags come straight from the registered level, so they always agree
    // with one another in every cycle.
    assign level     = level_q;
    assign full      = (level_q == (ADDR_W+1)'(DEPTH));
    assign empty     = (level_q == '0);
    assign out_valid = !empty;
    assign overflow  = overflow_q;
    assign wrap_pulse = wrap_q;

    // First-word-fall-through: the head entry is always visible. The head
    // slot is only rewritten when the FIFO is full and popping at the same
    // time, so out_data holds steady while the consumer stalls.
    assign out_data = mem[rd_ptr];

    // A push into a full FIFO is allowed only when the head is leaving in
    // the same cycle, which frees exactly the slot being written.
    assign pop  = out_valid & out_ready;
    assign push = capture & (!full | pop);

    // Storage array. Cleared on reset so out_data reads zero afterwards.
    // A flush discards any simultaneous capture, so no write occurs then.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push && !flush) begin
            mem[wr_ptr] <= count_in;
        end
    end

    // Pointers and occupancy. Flush takes priority over push and pop.
    // Pointers wrap naturally modulo DEPTH because DEPTH is a power of two.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            level_q <= '0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + (ADDR_W+1)'(1);
                2'b01:   level_q <= level_q - (ADDR_W+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Sticky overflow: set when a capture finds the buffer full with no
    // pop to make room. A capture during flush is silently dropped.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            overflow_q <= 1'b0;
        end else if (flush) begin
            overflow_q <= 1'b0;
        end else if (capture && full && !pop) begin
            overflow_q <= 1'b1;
        end
    end

    // Wrap detection only fires on an all-ones to zero step, so a counter
    // being cleared from some other value does not pulse. prev_count resets
    // to zero, which keeps the first cycle after reset from pulsing.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            prev_count <= '0;
            wrap_q     <= 1'b0;
        end else begin
            prev_count <= count_in;
            wrap_q     <= (prev_count == {WIDTH{1'b1}}) && (count_in == '0);
        end
    end

endmodule

// File: tb/tb_count_capture_fifo.sv
module tb_count_capture_fifo;

    localparam int WIDTH  = 4;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    logic              clock = 1'b0;
    logic              clear;
    logic [WIDTH-1:0]  count_in;
    logic              capture;
    logic              flush;
    logic [WIDTH-1:0]  out_data;
    logic              out_valid;
    logic              out_ready;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   level;
    logic              overflow;
    logic              wrap_pulse;

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    count_capture_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clock      (clock),
        .clear      (clear),
        .count_in   (count_in),
        .capture    (capture),
        .flush      (flush),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .full       (full),
        .empty      (empty),
        .level      (level),
        .overflow   (overflow),
        .wrap_pulse (wrap_pulse)
    );

    always #5 clock = ~clock;

    // Behavioural model: a queue of snapshots plus a sticky flag and the
    // last counter value seen.
    logic [WIDTH-1:0] m_q[$];
    bit               m_ovf  = 1'b0;
    logic [WIDTH-1:0] m_prev = '0;
    bit               m_wrap = 1'b0;
    bit               m_pop;
    bit               m_push;

    always @(posedge clock or negedge clear) begin
        if (!clear) begin
            m_q.delete();
            m_ovf  = 1'b0;
            m_prev = '0;
            m_wrap = 1'b0;
        end else begin
            m_wrap = (m_prev == 4'hF) && (count_in == 4'h0);
            m_prev = count_in;
            if (flush) begin
                m_q.delete();
                m_ovf = 1'b0;
            end else begin
                m_pop  = (m_q.size() != 0) && out_ready;
                m_push = capture && ((m_q.size() < DEPTH) || m_pop);
                if (m_pop) void'(m_q.pop_front());
                if (m_push) m_q.push_back(count_in);
                else if (capture) m_ovf = 1'b1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        if (check_en) begin
            checkOutput("m_level", 32'(level), 32'(m_q.size()));
            checkOutput("m_empty", 32'(empty), 32'(m_q.size() == 0));
            checkOutput("m_full", 32'(full), 32'(m_q.size() == DEPTH));
            checkOutput("m_valid", 32'(out_valid), 32'(m_q.size() != 0));
            checkOutput("m_overflow", 32'(overflow), 32'(m_ovf));
            checkOutput("m_wrap", 32'(wrap_pulse), 32'(m_wrap));
            if (m_q.size() != 0) checkOutput("m_data", 32'(out_data), 32'(m_q[0]));
        end
    end

    // Drive inputs at a falling edge, then let one rising edge pass.
    task automatic applyStimulus(input bit cap, input logic [3:0] cnt, input bit rdy, input bit fl);
        capture   = cap;
        count_in  = cnt;
        out_ready = rdy;
        flush     = fl;
        @(negedge clock);
    endtask

    initial begin
        clear = 1'b0; capture = 1'b0; flush = 1'b0; out_ready = 1'b0; count_in = '0;
        repeat (2) @(negedge clock);
        checkOutput("rst_level", 32'(level), 0);
        checkOutput("rst_empty", 32'(empty), 1);
        checkOutput("rst_full", 32'(full), 0);
        checkOutput("rst_valid", 32'(out_valid), 0);
        checkOutput("rst_ovf", 32'(overflow), 0);
        checkOutput("rst_wrap", 32'(wrap_pulse), 0);
        checkOutput("rst_data", 32'(out_data), 0);
        clear = 1'b1;
        check_en = 1'b1;

        // Three captures, then drain in order
        applyStimulus(1, 4'h3, 0, 0);
        checkOutput("t1_valid", 32'(out_valid), 1);
        checkOutput("t1_data0", 32'(out_data), 3);
        applyStimulus(1, 4'h4, 0, 0);
        applyStimulus(1, 4'h5, 0, 0);
        checkOutput("t1_level", 32'(level), 3);
        checkOutput("t1_hold", 32'(out_data), 3);
        applyStimulus(0, 4'h5, 1, 0);
        checkOutput("t1_data1", 32'(out_data), 4);
        applyStimulus(0, 4'h5, 1, 0);
        checkOutput("t1_data2", 32'(out_data), 5);
        applyStimulus(0, 4'h5, 1, 0);
        checkOutput("t1_valid_end", 32'(out_valid), 0);
        checkOutput("t1_empty_end", 32'(empty), 1);

        // Fill past capacity
        for (int i = 1; i <= 9; i++) begin
            applyStimulus(1, 4'(i), 0, 0);
            if (i == 8) begin
                checkOutput("t2_full8", 32'(full), 1);
                checkOutput("t2_ovf8", 32'(overflow), 0);
            end
        end
        checkOutput("t2_ovf9", 32'(overflow), 1);
        checkOutput("t2_level9", 32'(level), 8);
        for (int i = 1; i <= 8; i++) begin
            checkOutput("t2_drain", 32'(out_data), 32'(i));
            applyStimulus(0, 4'h0, 1, 0);
        end
        checkOutput("t2_empty", 32'(empty), 1);

        // Simultaneous push and pop while full
        applyStimulus(0, 4'h0, 0, 1);
        checkOutput("t3_flush_ovf", 32'(overflow), 0);
        for (int i = 1; i <= 8; i++) applyStimulus(1, 4'(i), 0, 0);
        applyStimulus(1, 4'hA, 1, 0);
        checkOutput("t3_level", 32'(level), 8);
        checkOutput("t3_ovf", 32'(overflow), 0);
        for (int i = 2; i <= 9; i++) begin
            checkOutput("t3_drain", 32'(out_data), (i == 9) ? 32'hA : 32'(i));
            applyStimulus(0, 4'h0, 1, 0);
        end
        checkOutput("t3_empty", 32'(empty), 1);

        // Wrap detection
        applyStimulus(0, 4'hE, 0, 0);
        applyStimulus(0, 4'hF, 0, 0);
        checkOutput("t4_pre", 32'(wrap_pulse), 0);
        applyStimulus(0, 4'h0, 0, 0);
        checkOutput("t4_pulse", 32'(wrap_pulse), 1);
        applyStimulus(0, 4'h1, 0, 0);
        checkOutput("t4_post", 32'(wrap_pulse), 0);
        applyStimulus(0, 4'h7, 0, 0);
        applyStimulus(0, 4'h0, 0, 0);
        checkOutput("t4_jump", 32'(wrap_pulse), 0);
        applyStimulus(0, 4'h0, 0, 0);
        checkOutput("t4_jump2", 32'(wrap_pulse), 0);

        // Flush beats capture with level 5 and overflow set
        for (int i = 1; i <= 9; i++) applyStimulus(1, 4'(i), 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 4'h0, 1, 0);
        checkOutput("t5_level", 32'(level), 5);
        checkOutput("t5_ovf", 32'(overflow), 1);
        applyStimulus(1, 4'h3, 0, 1);
        checkOutput("t5_f_level", 32'(level), 0);
        checkOutput("t5_f_empty", 32'(empty), 1);
        checkOutput("t5_f_ovf", 32'(overflow), 0);
        checkOutput("t5_f_valid", 32'(out_valid), 0);

        // Asynchronous reset mid-cycle
        for (int i = 1; i <= 4; i++) applyStimulus(1, 4'(i), 0, 0);
        checkOutput("t6_level", 32'(level), 4);
        capture = 1'b0;
        #2 clear = 1'b0;
        #1;
        checkOutput("t6_rst_level", 32'(level), 0);
        checkOutput("t6_rst_valid", 32'(out_valid), 0);
        checkOutput("t6_rst_empty", 32'(empty), 1);
        checkOutput("t6_rst_full", 32'(full), 0);
        checkOutput("t6_rst_ovf", 32'(overflow), 0);
        checkOutput("t6_rst_data", 32'(out_data), 0);
        @(negedge clock);
        clear = 1'b1;
        applyStimulus(1, 4'h2, 0, 0);
        checkOutput("t6_valid", 32'(out_valid), 1);
        checkOutput("t6_data", 32'(out_data), 2);
        applyStimulus(0, 4'h2, 1, 0);
        checkOutput("t6_empty", 32'(empty), 1);
        repeat (2) applyStimulus(0, 4'h2, 0, 0);

        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
